// File: rtl/multiclk_counter.sv
// multiclk_counter: counts rising edges of NCLK prescaled async test clocks over a common gate window.
// Latency: captures and o_update appear the cycle after the gate; the readout mux adds one registered cycle.
// Backpressure: none. Counts saturate at all-ones and set o_overflow. Optional min/max trackers: MULTICLK_COUNTER_MINMAX_EN.
module multiclk_counter #(
  parameter int NCLK         = 4,
  parameter int LGNAVGS      = 4,
  parameter int BUSW         = 32,
  parameter int CLOCKFREQ_HZ = 100_000_000,
  localparam int SELW        = (NCLK > 1) ? $clog2(NCLK) : 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_ext_pps,
  input  logic [NCLK-1:0] i_tst_div,
  input  logic [SELW-1:0] i_sel,
  input  logic            i_clr_minmax,
  output logic [BUSW-1:0] o_counts,
  output logic [BUSW-1:0] o_min_counts,
  output logic [BUSW-1:0] o_max_counts,
  output logic            o_valid,
  output logic            o_update,
  output logic [NCLK-1:0] o_overflow,
  output logic [NCLK-1:0] o_stopped
);

  localparam int CW = BUSW - LGNAVGS;

  (* ASYNC_REG = "TRUE" *) logic [NCLK-1:0] sync_a;
  (* ASYNC_REG = "TRUE" *) logic [NCLK-1:0] sync_b;
  logic [NCLK-1:0] hist;
  logic [NCLK-1:0] tick;

  logic            gate;
  logic [CW-1:0]   cnt     [NCLK];
  logic [CW-1:0]   capture [NCLK];
  logic [NCLK-1:0] sat;
  logic [NCLK-1:0] ovf_cap;
  logic            valid;
  logic            update;
  logic            seen;
  logic            sel_ok;
  logic            unused_inputs;

  // Inputs only consumed in some build/parameter combinations
  assign unused_inputs = ^{i_ext_pps, i_clr_minmax};

  // Two-flop synchronizer per test clock, plus a history bit for edge detection
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_a <= '0;
      sync_b <= '0;
      hist   <= '0;
    end else begin
      sync_a <= i_tst_div;
      sync_b <= sync_a;
      hist   <= sync_b;
    end
  end

  assign tick = sync_b & ~hist;

  generate
    if (CLOCKFREQ_HZ > 0) begin : g_timer
      localparam int TW = $clog2(CLOCKFREQ_HZ + 1);
      localparam logic [TW-1:0] TLAST = TW'(CLOCKFREQ_HZ - 1);
      logic [TW-1:0] timer;

      // Free-running gate timer: one gate every CLOCKFREQ_HZ cycles
      always_ff @(posedge i_clk) begin
        if (i_reset)             timer <= '0;
        else if (timer == TLAST) timer <= '0;
        else                     timer <= timer + 1'b1;
      end

      assign gate = (timer == TLAST);
    end else begin : g_pps
      assign gate = i_ext_pps;
    end
  endgenerate

  // Per-channel window counters; a tick on the gate cycle belongs to the new window
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int n = 0; n < NCLK; n++) begin
        cnt[n]     <= '0;
        capture[n] <= '0;
      end
      sat     <= '0;
      ovf_cap <= '0;
    end else begin
      for (int n = 0; n < NCLK; n++) begin
        if (gate) begin
          capture[n] <= cnt[n];
          ovf_cap[n] <= sat[n];
          cnt[n]     <= tick[n] ? CW'(1) : '0;
          sat[n]     <= 1'b0;
        end else if (tick[n]) begin
          if (&cnt[n]) sat[n] <= 1'b1;
          else         cnt[n] <= cnt[n] + 1'b1;
        end
      end
    end
  end

  // Valid after the first full window; an external gate's first window is partial
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid  <= 1'b0;
      update <= 1'b0;
      seen   <= 1'b0;
    end else begin
      update <= gate;
      if (gate) begin
        seen <= 1'b1;
        if (CLOCKFREQ_HZ > 0 || seen) valid <= 1'b1;
      end
    end
  end

  assign o_valid    = valid;
  assign o_update   = update;
  assign o_overflow = ovf_cap;

  // A channel is stopped when a valid window saw no edges at all
  always_comb begin
    o_stopped = '0;
    for (int n = 0; n < NCLK; n++) begin
      o_stopped[n] = valid && (capture[n] == '0);
    end
  end

  assign sel_ok = ({1'b0, i_sel} < (SELW + 1)'(NCLK));

  // Registered readout of the selected channel, scaled back up by the prescale
  always_ff @(posedge i_clk) begin
    if (i_reset)     o_counts <= '0;
    else if (sel_ok) o_counts <= BUSW'(capture[i_sel]) << LGNAVGS;
    else             o_counts <= '0;
  end

`ifdef MULTICLK_COUNTER_MINMAX_EN
  logic [CW-1:0] min_v [NCLK];
  logic [CW-1:0] max_v [NCLK];

  // Track extremes over complete windows only; a clear overrides a coincident update
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr_minmax) begin
      for (int n = 0; n < NCLK; n++) begin
        min_v[n] <= '1;
        max_v[n] <= '0;
      end
    end else if (gate && valid) begin
      for (int n = 0; n < NCLK; n++) begin
        if (cnt[n] < min_v[n]) min_v[n] <= cnt[n];
        if (cnt[n] > max_v[n]) max_v[n] <= cnt[n];
      end
    end
  end

  // Extremes read out through the same select and scaling as o_counts
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_min_counts <= '0;
      o_max_counts <= '0;
    end else if (sel_ok) begin
      o_min_counts <= BUSW'(min_v[i_sel]) << LGNAVGS;
      o_max_counts <= BUSW'(max_v[i_sel]) << LGNAVGS;
    end else begin
      o_min_counts <= '0;
      o_max_counts <= '0;
    end
  end
`else
  assign o_min_counts = '0;
  assign o_max_counts = '0;
`endif

endmodule

// File: tb/tb_multiclk_counter.sv
// Bench for multiclk_counter: three instances (internal gate, 8-bit saturating, external PPS gate).
// Reference model counts the rising edges each source actually produced inside each gate window.
`timescale 1ns/1ps
module tb_multiclk_counter;
  localparam int MAXC = 16384;
  localparam logic [31:0] A_MIN_NONE = 32'd65532;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, pps, clr;
  logic [1:0] a_sel;
  logic       b_sel;
  logic [1:0] c_sel;
  logic [7:0] src = '0;
  int per [8];
  int ph  [8];
  int cyc = 0;
  int t = 0;
  bit [7:0] rise_at [MAXC];
  int checks = 0;
  int failures = 0;

  logic [15:0] a_counts, a_min, a_max;
  logic        a_valid_o, a_update;
  logic [3:0]  a_ovf, a_stop;
  logic [7:0]  b_counts, b_min, b_max;
  logic        b_valid, b_update;
  logic [0:0]  b_ovf, b_stop;
  logic [15:0] c_counts, c_min, c_max;
  logic        c_valid, c_update;
  logic [2:0]  c_ovf, c_stop;

  int  exp_cnt [4];
  int  mn [4];
  int  mx [4];
  bit  mn_none [4];
  bit  m_valid;
  int  bg, g1, g2, g3;

  multiclk_counter #(.NCLK(4), .LGNAVGS(2), .BUSW(16), .CLOCKFREQ_HZ(1000)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_ext_pps(1'b0), .i_tst_div(src[3:0]), .i_sel(a_sel),
    .i_clr_minmax(clr), .o_counts(a_counts), .o_min_counts(a_min), .o_max_counts(a_max),
    .o_valid(a_valid_o), .o_update(a_update), .o_overflow(a_ovf), .o_stopped(a_stop));

  multiclk_counter #(.NCLK(1), .LGNAVGS(2), .BUSW(8), .CLOCKFREQ_HZ(1000)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_ext_pps(1'b0), .i_tst_div(src[4:4]), .i_sel(b_sel),
    .i_clr_minmax(1'b0), .o_counts(b_counts), .o_min_counts(b_min), .o_max_counts(b_max),
    .o_valid(b_valid), .o_update(b_update), .o_overflow(b_ovf), .o_stopped(b_stop));

  multiclk_counter #(.NCLK(3), .LGNAVGS(2), .BUSW(16), .CLOCKFREQ_HZ(0)) dut_c (
    .i_clk(clk), .i_reset(rst), .i_ext_pps(pps), .i_tst_div(src[7:5]), .i_sel(c_sel),
    .i_clr_minmax(1'b0), .o_counts(c_counts), .o_min_counts(c_min), .o_max_counts(c_max),
    .o_valid(c_valid), .o_update(c_update), .o_overflow(c_ovf), .o_stopped(c_stop));

  function automatic logic wave(input int p, input int phase);
    return (p > 0) && ((phase % p) < (p / 2));
  endfunction

  // Rising edges whose tick lands inside the window closed by gate g (previous gate gp)
  function automatic int edges(input int ch, input int gp, input int g);
    int n = 0;
    for (int ts = gp - 2; ts <= g - 3; ts++)
      if (ts >= 0 && ts < MAXC && rise_at[ts][ch]) n++;
    return n;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Test-clock sources; log the posedge at which each rising edge is first sampled
  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) begin
      ph[i]  <= ph[i] + 1;
      src[i] <= wave(per[i], ph[i] + 1);
      if (wave(per[i], ph[i] + 1) && !src[i] && (cyc + 1 < MAXC)) rise_at[cyc + 1][i] <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input logic [31:0] obs, input int exp);
    logic ok;
    ok = (int'(obs) + 4 >= exp) && (int'(obs) <= exp + 4);
    checks++;
    assert (ok === 1'b1) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d(+-4)", tag, obs, exp);
    end
  endtask

  task automatic adv(input int k);
    while (t < k) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic minmax_clear();
    for (int ch = 0; ch < 4; ch++) begin
      mn_none[ch] = 1'b1;
      mn[ch] = 0;
      mx[ch] = 0;
    end
  endtask

  task automatic a_gate();
    chk("a_update_gate", a_update, 1);
    chk("a_valid_gate", a_valid_o, 1);
    for (int ch = 0; ch < 4; ch++) begin
      exp_cnt[ch] = edges(ch, cyc - 1000, cyc);
      if (m_valid) begin
        if (mn_none[ch] || exp_cnt[ch] < mn[ch]) begin
          mn[ch] = exp_cnt[ch];
          mn_none[ch] = 1'b0;
        end
        if (exp_cnt[ch] > mx[ch]) mx[ch] = exp_cnt[ch];
      end
    end
    m_valid = 1'b1;
  endtask

  task automatic a_read_all();
    logic [3:0] stop_exp;
    stop_exp = '0;
    for (int ch = 0; ch < 4; ch++) stop_exp[ch] = (exp_cnt[ch] == 0);
    for (int s = 0; s < 4; s++) begin
      a_sel = 2'(s);
      adv(t + 1);
      if (s == 0) chk("a_update_once", a_update, 0);
      chk_near($sformatf("a_cnt%0d", s), a_counts, exp_cnt[s] * 4);
`ifdef MULTICLK_COUNTER_MINMAX_EN
      if (mn_none[s]) chk($sformatf("a_min%0d", s), a_min, A_MIN_NONE);
      else            chk_near($sformatf("a_min%0d", s), a_min, mn[s] * 4);
      chk_near($sformatf("a_max%0d", s), a_max, mx[s] * 4);
`else
      chk($sformatf("a_min%0d", s), a_min, 0);
      chk($sformatf("a_max%0d", s), a_max, 0);
`endif
    end
    chk("a_ovf", a_ovf, 0);
    chk("a_stopped", a_stop, stop_exp);
  endtask

  initial begin
    rst = 1'b1; pps = 1'b0; clr = 1'b0;
    a_sel = '0; b_sel = 1'b0; c_sel = '0;
    per[0] = 10; per[1] = 20; per[2] = 4; per[3] = 0;
    per[4] = 2;  per[5] = 10; per[6] = 0; per[7] = 0;
    minmax_clear();
    m_valid = 1'b0;
    repeat (4) @(negedge clk);

    chk("rst_a_counts", a_counts, 0);
    chk("rst_a_min", a_min, 0);
    chk("rst_a_max", a_max, 0);
    chk("rst_a_valid", a_valid_o, 0);
    chk("rst_a_update", a_update, 0);
    chk("rst_a_ovf", a_ovf, 0);
    chk("rst_a_stop", a_stop, 0);
    chk("rst_b_counts", b_counts, 0);
    chk("rst_b_minmax", {b_min, b_max}, 0);
    chk("rst_c_flags", {c_valid, c_update, c_ovf, c_stop}, 0);
    chk("rst_c_minmax", {c_min, c_max}, 0);

    // First windows on the internal gate
    rst = 1'b0; t = 0;
    adv(999);
    chk("a_update_early", a_update, 0);
    chk("a_valid_early", a_valid_o, 0);
    adv(1000);
    a_gate();
    chk("b_update", b_update, 1);
    chk("b_valid", b_valid, 1);
    chk("c_update_nopps", c_update, 0);
    per[4] = 100;
    adv(1001);
    chk("b_sat_cnt", b_counts, 252);
    chk("b_ovf_set", b_ovf, 1);
    chk("b_stop", b_stop, 0);
    b_sel = 1'b1;
    adv(1002);
    chk("b_sel_oob", b_counts, 0);
    b_sel = 1'b0;
    a_read_all();
    adv(2000);
    a_gate();
    bg = cyc;
    adv(2001);
    chk_near("b_slow_cnt", b_counts, 4 * edges(4, bg - 1000, bg));
    chk("b_ovf_clr", b_ovf, 0);
    a_read_all();

    // Reset in the middle of a window
    adv(2500);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_a_counts", a_counts, 0);
    chk("mid_rst_a_flags", {a_valid_o, a_update, a_ovf, a_stop}, 0);
    chk("mid_rst_a_minmax", {a_min, a_max}, 0);
    chk("mid_rst_b_counts", b_counts, 0);
    rst = 1'b0; t = 0;
    minmax_clear();
    m_valid = 1'b0;

    // External PPS gate on instance C, alongside A's restarted window
    adv(100); pps = 1'b1; g1 = cyc + 1;
    adv(101); pps = 1'b0;
    chk("c_update1", c_update, 1);
    chk("c_valid_partial", c_valid, 0);
    chk("c_stop_invalid", c_stop, 0);
    adv(600); pps = 1'b1; g2 = cyc + 1;
    chk("c_valid_before2", c_valid, 0);
    adv(601); pps = 1'b0;
    chk("c_update2", c_update, 1);
    chk("c_valid2", c_valid, 1);
    chk("c_stop", c_stop, 3'b110);
    adv(602);
    chk_near("c_cnt_w1", c_counts, 4 * edges(5, g1, g2));
    adv(999);
    chk("a_update_restart", a_update, 0);
    chk("a_valid_restart", a_valid_o, 0);
    adv(1000);
    a_gate();
    a_read_all();
    adv(1100); pps = 1'b1; g3 = cyc + 1;
    adv(1101); pps = 1'b0;
    adv(1102);
    chk_near("c_cnt_w2", c_counts, 4 * edges(5, g2, g3));
    c_sel = 2'd3;
    adv(1103);
    chk("c_sel_oob", c_counts, 0);

    // Randomized periods, one new set per window, with a min/max clear mid-run
    for (int k = 2; k <= 6; k++) begin
      for (int ch = 0; ch < 3; ch++) per[ch] = int'($urandom_range(40, 2));
      if (k == 4) begin
        adv(1000 * k - 500);
        clr = 1'b1;
        adv(t + 1);
        clr = 1'b0;
        a_sel = 2'd0;
        minmax_clear();
        adv(t + 1);
`ifdef MULTICLK_COUNTER_MINMAX_EN
        chk("a_min_cleared", a_min, A_MIN_NONE);
`else
        chk("a_min_cleared", a_min, 0);
`endif
        chk("a_max_cleared", a_max, 0);
      end
      adv(1000 * k);
      a_gate();
      a_read_all();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multiclk_counter.md
Name: multiclk_counter

Overview:
- Multi-channel successor to the single-clock frequency counter.
- Measures NCLK asynchronous test clocks, each already prescaled by 2^LGNAVGS, over a common gate window in the i_clk domain.
- Per-channel counts are captured at each gate; a channel-select mux reads them out on the status bus.
- Adds saturation/overflow, stopped-clock and valid flags, plus a gate from either an internal timer or an external PPS.

Parameters:
NCLK, 4, number of measured channels (1..16)
LGNAVGS, 4, log2 of external prescale on each i_tst_div bit; also the output left-shift
BUSW, 32, width of o_counts/o_min_counts/o_max_counts
CLOCKFREQ_HZ, 100_000_000, i_clk frequency; gate period = CLOCKFREQ_HZ cycles; 0 selects i_ext_pps as gate

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous active-high reset
i_ext_pps  in  1  gate strobe, i_clk domain; used only when CLOCKFREQ_HZ==0
i_tst_div  in  NCLK  asynchronous prescaled test-clock MSBs, one per channel
i_sel  in  max(1,$clog2(NCLK))  channel readout select
i_clr_minmax  in  1  clears min/max trackers (MINMAX_EN only)
o_counts  out  BUSW  selected channel count, scaled by 2^LGNAVGS
o_min_counts  out  BUSW  selected channel minimum
o_max_counts  out  BUSW  selected channel maximum
o_valid  out  1  at least one complete window captured
o_update  out  1  one-cycle pulse when captures refresh
o_overflow  out  NCLK  per-channel counter saturated in last window
o_stopped  out  NCLK  per-channel zero edges in last window (qualified by o_valid)

Behaviour:
- Clock/reset: single clock i_clk; reset i_reset is synchronous and active-high. All state clears on reset: sync flops, counters, captures, timer, and all outputs 0. Exception: internal min trackers reset to all-ones.
- Sync: each i_tst_div bit passes through a 2-flop ASYNC_REG synchronizer plus one history flop. tick[n] = rising edge of the synchronized signal (sync high, history low).
- Gate:
  - CLOCKFREQ_HZ>0: timer counts 0..CLOCKFREQ_HZ-1, width $clog2(CLOCKFREQ_HZ+1). gate pulses for one cycle when the timer reaches CLOCKFREQ_HZ-1, then the timer wraps to 0. i_ext_pps is ignored.
  - CLOCKFREQ_HZ==0: gate = i_ext_pps.
- Counters: width CW = BUSW-LGNAVGS, one per channel.
  - On gate: capture[n] <= cnt[n]; ovf_cap[n] <= sat[n]; cnt[n] <= tick[n] ? 1 : 0, so a tick coincident with the gate counts toward the new window; sat[n] <= 0.
  - Otherwise, on tick: if cnt is all-ones, hold it and set sat[n]; else increment.
- Valid:
  - Internal gate: o_valid rises with the first capture after reset.
  - External gate: the first window is partial, so o_valid rises on the second gate after reset.
  - o_valid stays high until reset.
- o_update: asserts the cycle after each gate, i.e. when captures are visible. Asserts on every gate, even while o_valid is 0.
- o_overflow = ovf_cap. o_stopped[n] = o_valid && capture[n]==0.
- Readout: o_counts <= {capture[i_sel], LGNAVGS zeros}, registered, one-cycle latency from i_sel or capture change. i_sel >= NCLK gives o_counts = 0. o_min_counts and o_max_counts are muxed identically.
- Reset mid-window: the window restarts from timer 0 and the partial count is discarded.

Optional Feature:
- Macro: MULTICLK_COUNTER_MINMAX_EN.
- With the macro:
  - Per-channel min (reset all-ones) and max (reset 0) are updated on each gate only while o_valid is already 1, so partial windows are never used.
  - i_clr_minmax returns min to all-ones and max to 0. If i_clr_minmax coincides with an update, the clear wins.
  - Outputs are the selected channel's values, shifted by LGNAVGS like o_counts.
- Without the macro: o_min_counts and o_max_counts are constant 0, i_clr_minmax is unused, and no tracker registers are built.

Test Plan:
1. Bench config CLOCKFREQ_HZ=1000, LGNAVGS=2, BUSW=16, NCLK=4.
   - Stimulus: i_tst_div[0] with period 10 cycles (5 high / 5 low), i_sel=0.
   - Required: after first gate, o_update pulses once, o_valid=1, o_counts = 100<<2 = 400 (±4 for phase); steady every 1000 cycles.
2. Channels 1/2/3 with periods 20, 4 and held low.
   - Sweep i_sel 1..3: o_counts = 200, 1000, 0 (each ±4), one cycle after each i_sel change.
   - o_stopped = 4'b1000.
   - i_sel ≥ NCLK is untestable here since NCLK=4 fills the 2-bit select; in an NCLK=3 configuration, drive i_sel=3 -> o_counts=0.
3. Overflow: config BUSW=8, LGNAVGS=2, CLOCKFREQ_HZ=1000, channel 0 period 2.
   - Required: count saturates at 63, o_overflow[0]=1, o_counts = 252.
   - Then slow channel 0 to period 100: next window o_overflow[0]=0, o_counts = 10<<2 = 40.
4. CLOCKFREQ_HZ=0: pulse i_ext_pps at cycles 100, 600, 1100 with period-10 input.
   - Required: o_valid stays 0 until after cycle 600; o_counts = 200 after cycle 1101.
5. Assert i_reset at cycle 500 of a window, held 3 cycles.
   - Required: all outputs 0 and o_valid=0.
   - Next gate is exactly 1000 cycles after reset release; that capture is the full 400.
6. MINMAX_EN build: alternate channel 0 period 10 / 8 per window.
   - Required: o_min_counts=400 and o_max_counts=500 (±4).
   - Pulse i_clr_minmax: min/max reflect only subsequent windows.
